// File: rtl/lcd_frame_builder.sv
// Registered frame builder for the character-LCD driver: captures an operation,
// converts the 16-bit result to BCD by double-dabble and packs an 18-byte frame.
module lcd_frame_builder #(
   parameter bit         SIGNED_VALUE = 1'b1,
   parameter logic [7:0] LINE2_CMD    = 8'hC0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [2:0]    opcode,
   input  logic [3:0]    destino,
   input  logic [15:0]   value,
   output logic [143:0]  palavra,
   output logic [17:0]   rs_list,
   output logic          busy,
   output logic          frame_valid
);

   // Handshake: start is a one-cycle request honoured only in IDLE (busy=0);
   // frame_valid pulses for one cycle when palavra/rs_list take a new frame.
   typedef enum logic [1:0] {IDLE, CONV, PACK} state_t;

   localparam logic [143:0] RESET_FRAME = {{6{8'h20}}, LINE2_CMD, {11{8'h20}}};
   localparam logic [17:0]  RS_FRAME    = 18'h3F7FF;

   state_t      state;
   logic [2:0]  op_r;
   logic [3:0]  dst_r;
   logic        neg_r;
   logic [15:0] mag;
   logic [19:0] bcd;
   logic [3:0]  cnt;

   logic [19:0]  bcd_adj;
   logic [143:0] frame;
   logic         lead;
   logic [3:0]   digit;

   function automatic logic [31:0] mnemonic(input logic [2:0] op);
      logic [31:0] m;
      case (op)
         3'd0:    m = {"D", "A", "O", "L"};
         3'd1:    m = {" ", "D", "D", "A"};
         3'd2:    m = {"I", "D", "D", "A"};
         3'd3:    m = {" ", "B", "U", "S"};
         3'd4:    m = {"I", "B", "U", "S"};
         3'd5:    m = {" ", "L", "U", "M"};
         3'd6:    m = {" ", "R", "L", "C"};
         default: m = {" ", "L", "P", "D"};
      endcase
      return m;
   endfunction

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 5; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // Byte 13 holds the ten-thousands digit; blanking stops at the first non-zero.
   always_comb begin
      frame = RESET_FRAME;
      lead  = 1'b1;
      digit = 4'd0;
      frame[31:0]   = mnemonic(op_r);
      frame[39:32]  = " ";
      frame[47:40]  = "[";
      for (int i = 0; i < 4; i++)
         frame[8*(6+i) +: 8] = dst_r[3-i] ? "1" : "0";
      frame[87:80]  = "]";
      frame[95:88]  = LINE2_CMD;
      frame[103:96] = neg_r ? "-" : " ";
      for (int k = 4; k >= 1; k--) begin
         digit = bcd[4*k +: 4];
         if (lead && digit == 4'd0) begin
            frame[8*(17-k) +: 8] = 8'h20;
         end else begin
            lead = 1'b0;
            frame[8*(17-k) +: 8] = 8'h30 | {4'h0, digit};
         end
      end
      frame[143:136] = 8'h30 | {4'h0, bcd[3:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         frame_valid <= 1'b0;
         palavra     <= RESET_FRAME;
         rs_list     <= RS_FRAME;
         op_r        <= 3'd0;
         dst_r       <= 4'd0;
         neg_r       <= 1'b0;
         mag         <= 16'd0;
         bcd         <= 20'd0;
         cnt         <= 4'd0;
      end else begin
         frame_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_r  <= opcode;
                  dst_r <= destino;
                  neg_r <= SIGNED_VALUE && value[15];
                  mag   <= (SIGNED_VALUE && value[15]) ? (~value + 16'd1) : value;
                  bcd   <= 20'd0;
                  cnt   <= 4'd0;
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               {bcd, mag} <= {bcd_adj, mag} << 1;
               cnt        <= cnt + 4'd1;
               if (cnt == 4'd15)
                  state <= PACK;
            end
            PACK: begin
               palavra     <= frame;
               rs_list     <= RS_FRAME;
               frame_valid <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_frame_builder.sv
// Directed bench for lcd_frame_builder: signed and unsigned builds share stimulus,
// frames are compared against hand-written text.
module tb_lcd_frame_builder;

   logic          clk;
   logic          rst;
   logic          start;
   logic [2:0]    opcode;
   logic [3:0]    destino;
   logic [15:0]   value;
   logic [143:0]  p_s, p_u;
   logic [17:0]   rs_s, rs_u;
   logic          busy_s, busy_u;
   logic          fv_s, fv_u;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [143:0] RESET_F = {{6{8'h20}}, 8'hC0, {11{8'h20}}};

   lcd_frame_builder #(.SIGNED_VALUE(1'b1), .LINE2_CMD(8'hC0)) u_signed (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .destino(destino),
      .value(value), .palavra(p_s), .rs_list(rs_s), .busy(busy_s), .frame_valid(fv_s)
   );

   lcd_frame_builder #(.SIGNED_VALUE(1'b0), .LINE2_CMD(8'hC0)) u_unsigned (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .destino(destino),
      .value(value), .palavra(p_u), .rs_list(rs_u), .busy(busy_u), .frame_valid(fv_u)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [143:0] frame_of(input string l1, input string l2);
      logic [143:0] f;
      f = '0;
      for (int i = 0; i < 11; i++) f[8*i +: 8] = l1[i];
      f[95:88] = 8'hC0;
      for (int i = 0; i < 6; i++) f[8*(12+i) +: 8] = l2[i];
      return f;
   endfunction

   task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; start is sampled at the following posedge.
   task automatic drive_start(input logic [2:0] op, input logic [3:0] d, input logic [15:0] v);
      opcode  = op;
      destino = d;
      value   = v;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      opcode  = 3'($urandom_range(0, 7));
      destino = 4'($urandom_range(0, 15));
      value   = 16'($urandom_range(0, 65535));
   endtask

   // Entered at the negedge right after the capture edge; returns on the pulse.
   task automatic wait_frame(input string tag, input logic [143:0] held);
      int j, bc, chg;
      j = 0; bc = 0; chg = 0;
      while (!fv_s && j < 40) begin
         if (busy_s) bc++;
         if (p_s !== held) chg++;
         @(negedge clk);
         j++;
      end
      chk({tag, " latency"}, j, 17);
      chk({tag, " busy_cycles"}, bc, 17);
      chk({tag, " held_during_conv"}, chg, 0);
      chk({tag, " busy_at_pulse"}, busy_s, 1'b0);
      chk({tag, " fv_unsigned"}, fv_u, 1'b1);
   endtask

   initial begin
      logic [143:0] got;
      int pulses;
      rst = 1'b0; start = 1'b0; opcode = 3'd0; destino = 4'd0; value = 16'd0;
      #2 rst = 1'b1;
      #1;
      chk("reset palavra", p_s, RESET_F);
      chk("reset rs_list", rs_s, 18'h3F7FF);
      chk("reset busy", busy_s, 1'b0);
      chk("reset frame_valid", fv_s, 1'b0);
      chk("reset palavra unsigned", p_u, RESET_F);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      drive_start(3'd0, 4'd5, 16'd1234);
      wait_frame("load", RESET_F);
      chk("load frame", p_s, frame_of("LOAD [0101]", "  1234"));
      chk("load rs_list", rs_s, 18'h3F7FF);
      @(negedge clk);
      chk("load pulse width", fv_s, 1'b0);

      drive_start(3'd3, 4'd10, 16'h8000);
      wait_frame("sub_min", frame_of("LOAD [0101]", "  1234"));
      chk("sub_min frame", p_s, frame_of("SUB  [1010]", "-32768"));
      chk("sub_min unsigned", p_u, frame_of("SUB  [1010]", " 32768"));
      @(negedge clk);

      drive_start(3'd3, 4'd10, 16'hFFFF);
      wait_frame("sub_m1", frame_of("SUB  [1010]", "-32768"));
      chk("sub_m1 frame", p_s, frame_of("SUB  [1010]", "-    1"));
      @(negedge clk);

      drive_start(3'd3, 4'd10, 16'h0000);
      wait_frame("sub_zero", frame_of("SUB  [1010]", "-    1"));
      chk("sub_zero frame", p_s, frame_of("SUB  [1010]", "     0"));
      @(negedge clk);

      drive_start(3'd5, 4'd12, 16'hFFFF);
      wait_frame("mul", frame_of("SUB  [1010]", "     0"));
      chk("mul signed", p_s, frame_of("MUL  [1100]", "-    1"));
      chk("mul unsigned", p_u, frame_of("MUL  [1100]", " 65535"));
      chk("mul unsigned rs", rs_u, 18'h3F7FF);
      @(negedge clk);

      drive_start(3'd6, 4'd3, 16'd100);
      wait_frame("clr", frame_of("MUL  [1100]", "-    1"));
      chk("clr frame", p_s, frame_of("CLR  [0011]", "   100"));
      @(negedge clk);

      drive_start(3'd7, 4'd15, 16'h7FFF);
      wait_frame("dpl", frame_of("CLR  [0011]", "   100"));
      chk("dpl frame", p_s, frame_of("DPL  [1111]", " 32767"));
      @(negedge clk);

      // Second start five cycles into the conversion must be dropped.
      drive_start(3'd2, 4'd1, 16'd42);
      repeat (4) @(negedge clk);
      opcode = 3'd4; destino = 4'd9; value = 16'd999; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pulses = 0;
      got = '0;
      for (int i = 0; i < 40; i++) begin
         if (fv_s) begin
            pulses++;
            got = p_s;
         end
         @(negedge clk);
      end
      chk("busy_ignore pulses", pulses, 1);
      chk("busy_ignore frame", got, frame_of("ADDI [0001]", "    42"));
      chk("busy_ignore idle", busy_s, 1'b0);

      drive_start(3'd1, 4'd6, 16'd500);
      wait_frame("add", frame_of("ADDI [0001]", "    42"));
      chk("add frame", p_s, frame_of("ADD  [0110]", "   500"));
      drive_start(3'd4, 4'd9, 16'd999);
      chk("b2b pulse width", fv_s, 1'b0);
      wait_frame("b2b", frame_of("ADD  [0110]", "   500"));
      chk("b2b frame", p_s, frame_of("SUBI [1001]", "   999"));
      @(negedge clk);

      drive_start(3'd0, 4'd2, 16'd7);
      repeat (8) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst busy", busy_s, 1'b0);
      chk("midrst frame_valid", fv_s, 1'b0);
      chk("midrst palavra", p_s, RESET_F);
      chk("midrst rs_list", rs_s, 18'h3F7FF);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         if (fv_s) pulses++;
         @(negedge clk);
      end
      chk("midrst no pulse", pulses, 0);
      chk("midrst held", p_s, RESET_F);

      drive_start(3'd0, 4'd8, 16'd12345);
      wait_frame("after_rst", RESET_F);
      chk("after_rst frame", p_s, frame_of("LOAD [1000]", " 12345"));
      @(negedge clk);
      chk("after_rst pulse width", fv_s, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
